// File: rtl/pixel_link_pkg.sv
// pixel_link_pkg: shared constants and types for the HPS pixel link receiver.
// Holds the status bit positions for both handshake directions, the receiver
// state enum and the default frame geometry.
package pixel_link_pkg;

   localparam int H_RES_DEFAULT = 640;
   localparam int V_RES_DEFAULT = 480;

   // pixel_status_write bit positions (bit 3 reserved)
   localparam int SW_VALID       = 0;
   localparam int SW_FRAME_START = 1;
   localparam int SW_ROW_DONE    = 2;

   // pixel_status_read bit positions
   localparam int SR_ACK        = 0;
   localparam int SR_READY      = 1;
   localparam int SR_FRAME_DONE = 2;
   localparam int SR_ERROR      = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_REQ = 3'd1,
      ST_WRITE    = 3'd2,
      ST_WAIT_REL = 3'd3,
      ST_ROW_ADV  = 3'd4
   } state_e;

endpackage

// File: rtl/pixel_link_sync.sv
// pixel_link_sync: per-bit two-flop synchronizer for the HPS control lines.
// Only instantiated when PIXEL_LINK_IN_SYNC_EN is defined. Both stages clear
// to 0 on reset so a reset never leaves a stale request in flight.
module pixel_link_sync #(
   parameter int W = 3
) (
   input  logic         clk_clk,
   input  logic         reset_reset_n,
   input  logic [W-1:0] d_in,
   output logic [W-1:0] d_out
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   // shift the raw bits through the two stages
   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end

   // synchronizer flops, synchronous active-low clear
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign d_out = sync_q;

endmodule

// File: rtl/pixel_link_receiver.sv
// pixel_link_receiver: receives pixels from the HPS over a four-phase
// handshake and writes them to the frame buffer at row*H_RES + index.
// The row base is kept in an accumulator stepped by H_RES per row, so no
// multiplier is needed. Build option: PIXEL_LINK_IN_SYNC_EN puts a two-flop
// synchronizer in front of the control register (two extra cycles latency).
//
// state       | meaning
// ST_IDLE     | no frame in progress, waiting for FRAME_START
// ST_WAIT_REQ | READY high, waiting for VALID (wins) or ROW_DONE
// ST_WRITE    | one-cycle buffer write, or sticky ERROR if index out of row
// ST_WAIT_REL | ACK held until VALID and ROW_DONE are both seen low
// ST_ROW_ADV  | advance row, or wrap to 0 and flag FRAME_DONE
module pixel_link_receiver
   import pixel_link_pkg::*;
#(
   parameter int H_RES = H_RES_DEFAULT,
   parameter int V_RES = V_RES_DEFAULT,
   parameter int FB_AW = 19
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [23:0]      pixel_data,
   input  logic [15:0]      pixel_index_in_row,
   input  logic [3:0]       pixel_status_write,
   output logic [15:0]      pixel_row,
   output logic [3:0]       pixel_status_read,
   output logic             fb_we,
   output logic [FB_AW-1:0] fb_addr,
   output logic [23:0]      fb_data
);

   localparam logic [31:0] H_STEP   = 32'(H_RES);
   localparam logic [15:0] ROW_LAST = 16'(V_RES - 1);

   logic [2:0]  ctrl_in;
   logic        unused_rsvd;

   logic [2:0]  ctrl_q, ctrl_d;
   logic [23:0] din_q, din_d;
   logic [15:0] idx_q, idx_d;

   state_e      state_q, state_d;
   logic [15:0] row_q, row_d;
   logic [31:0] base_q, base_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [23:0] pix_q, pix_d;
   logic [15:0] pidx_q, pidx_d;

   logic        valid_s, start_s, rdone_s;
   logic        abort;
   logic        idx_ok;
   logic        ack, ready;

   assign unused_rsvd = pixel_status_write[3];

`ifdef PIXEL_LINK_IN_SYNC_EN
   pixel_link_sync #(.W(3)) u_sync (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .d_in          (pixel_status_write[2:0]),
      .d_out         (ctrl_in)
   );
`else
   assign ctrl_in = pixel_status_write[2:0];
`endif

   assign valid_s = ctrl_q[SW_VALID];
   assign start_s = ctrl_q[SW_FRAME_START];
   assign rdone_s = ctrl_q[SW_ROW_DONE];

   // FRAME_START outside IDLE cancels whatever is in progress
   assign abort  = start_s && (state_q != ST_IDLE);
   assign idx_ok = ({16'd0, pidx_q} < H_STEP);

   // control, data and index are captured together in one register stage
   always_comb begin
      ctrl_d = ctrl_in;
      din_d  = pixel_data;
      idx_d  = pixel_index_in_row;
   end

   // input register
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         ctrl_q <= '0;
         din_q  <= '0;
         idx_q  <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         din_q  <= din_d;
         idx_q  <= idx_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; release needs both requests low so a held ROW_DONE
   // cannot piggy-back on a pixel handshake
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_WAIT_REQ;
      end else begin
         case (state_q)
            ST_IDLE:     if (start_s) state_d = ST_WAIT_REQ;
            ST_WAIT_REQ: begin
               if (valid_s)      state_d = ST_WRITE;
               else if (rdone_s) state_d = ST_ROW_ADV;
            end
            ST_WRITE:    state_d = ST_WAIT_REL;
            ST_WAIT_REL: begin
               if (!valid_s && !rdone_s) state_d = done_q ? ST_IDLE : ST_WAIT_REQ;
            end
            ST_ROW_ADV:  state_d = ST_WAIT_REL;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   // row/base accumulator, sticky flags and pending-pixel latch
   always_comb begin
      row_d  = row_q;
      base_d = base_q;
      done_d = done_q;
      err_d  = err_q;
      pix_d  = pix_q;
      pidx_d = pidx_q;
      if (start_s) begin
         row_d  = '0;
         base_d = '0;
         done_d = 1'b0;
         err_d  = 1'b0;
      end else begin
         case (state_q)
            ST_WAIT_REQ: begin
               if (valid_s) begin
                  pix_d  = din_q;
                  pidx_d = idx_q;
               end
            end
            ST_WRITE: begin
               if (!idx_ok) err_d = 1'b1;
            end
            ST_ROW_ADV: begin
               if (row_q < ROW_LAST) begin
                  row_d  = row_q + 16'd1;
                  base_d = base_q + H_STEP;
               end else begin
                  row_d  = '0;
                  base_d = '0;
                  done_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // datapath registers
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         row_q  <= '0;
         base_q <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         pix_q  <= '0;
         pidx_q <= '0;
      end else begin
         row_q  <= row_d;
         base_q <= base_d;
         done_q <= done_d;
         err_q  <= err_d;
         pix_q  <= pix_d;
         pidx_q <= pidx_d;
      end
   end

   // FSM outputs; an abort cycle suppresses ACK, READY and the write
   always_comb begin
      ack     = 1'b0;
      ready   = 1'b0;
      fb_we   = 1'b0;
      fb_addr = '0;
      fb_data = '0;
      if (!abort) begin
         case (state_q)
            ST_WAIT_REQ: ready = 1'b1;
            ST_WRITE: begin
               ack = 1'b1;
               if (idx_ok) begin
                  fb_we   = 1'b1;
                  fb_addr = FB_AW'(base_q + 32'(pidx_q));
                  fb_data = pix_q;
               end
            end
            ST_WAIT_REL: ack = 1'b1;
            ST_ROW_ADV:  ack = 1'b1;
            default: ;
         endcase
      end
   end

   // status word back to the HPS
   always_comb begin
      pixel_status_read                = '0;
      pixel_status_read[SR_ACK]        = ack;
      pixel_status_read[SR_READY]      = ready;
      pixel_status_read[SR_FRAME_DONE] = done_q;
      pixel_status_read[SR_ERROR]      = err_q;
   end

   assign pixel_row = row_q;

endmodule

// File: tb/tb_pixel_link_receiver.sv
// tb_pixel_link_receiver: directed handshake scenarios with a per-cycle
// reference model of the link protocol plus literal spot checks.
module tb_pixel_link_receiver;
   import pixel_link_pkg::*;

   localparam int H  = 640;
   localparam int V  = 480;
   localparam int AW = 19;
`ifdef PIXEL_LINK_IN_SYNC_EN
   localparam int D = 3;
`else
   localparam int D = 1;
`endif
   localparam int LAT = D + 1;

   logic          clk_clk;
   logic          reset_reset_n;
   logic [23:0]   pixel_data;
   logic [15:0]   pixel_index_in_row;
   logic [3:0]    pixel_status_write;
   logic [15:0]   pixel_row;
   logic [3:0]    pixel_status_read;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [23:0]   fb_data;

   int n_total = 0;
   int n_pass  = 0;

   pixel_link_receiver #(.H_RES(H), .V_RES(V), .FB_AW(AW)) dut (
      .clk_clk            (clk_clk),
      .reset_reset_n      (reset_reset_n),
      .pixel_data         (pixel_data),
      .pixel_index_in_row (pixel_index_in_row),
      .pixel_status_write (pixel_status_write),
      .pixel_row          (pixel_row),
      .pixel_status_read  (pixel_status_read),
      .fb_we              (fb_we),
      .fb_addr            (fb_addr),
      .fb_data            (fb_data)
   );

   initial begin
      clk_clk = 1'b0;
      forever #5 clk_clk = ~clk_clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // ph: 0 no frame, 1 ready for request, 2 writing, 3 awaiting release, 4 advancing
   int          ph;
   int          m_row;
   bit          m_done, m_err;
   logic [23:0] m_sd, m_wd;
   int          m_sidx, m_widx;
   logic [2:0]  pipe [D];
   bit          model_on = 1'b0;

   always @(posedge clk_clk) begin : model
      logic [2:0] s;
      s = pipe[D-1];
      if (!reset_reset_n) begin
         ph = 0; m_row = 0; m_done = 0; m_err = 0;
         m_sd = '0; m_wd = '0; m_sidx = 0; m_widx = 0;
         for (int i = 0; i < D; i++) pipe[i] = 3'b000;
      end else begin
         if (s[1]) begin
            ph = 1; m_row = 0; m_done = 0; m_err = 0;
         end else begin
            case (ph)
               1: if (s[0]) begin ph = 2; m_wd = m_sd; m_widx = m_sidx; end
                  else if (s[2]) ph = 4;
               2: begin if (m_widx >= H) m_err = 1; ph = 3; end
               3: if (!s[0] && !s[2]) ph = m_done ? 0 : 1;
               4: begin
                  if (m_row == V - 1) begin m_row = 0; m_done = 1; end
                  else m_row = m_row + 1;
                  ph = 3;
               end
               default: ;
            endcase
         end
         for (int i = D - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = pixel_status_write[2:0];
         m_sd   = pixel_data;
         m_sidx = int'(pixel_index_in_row);
      end
      model_on = 1'b1;
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk_clk) begin : compare
      logic [2:0]    s;
      bit            abort, ewe, eack, erdy;
      logic [AW-1:0] ea;
      logic [23:0]   ed;
      logic [3:0]    est;
      if (model_on) begin
         s     = pipe[D-1];
         abort = s[1] && (ph != 0);
         ewe   = !abort && (ph == 2) && (m_widx < H);
         ea    = ewe ? AW'(m_row * H + m_widx) : '0;
         ed    = ewe ? m_wd : '0;
         eack  = !abort && (ph == 2 || ph == 3 || ph == 4);
         erdy  = !abort && (ph == 1);
         est   = {m_err, m_done, erdy, eack};
         n_total++;
         if (fb_we === ewe && fb_addr === ea && fb_data === ed &&
             pixel_status_read === est && pixel_row === 16'(m_row))
            n_pass++;
         else
            $display("FAIL cycle_model @%0t: got we=%b addr=%0d data=%h st=%b row=%0d, need we=%b addr=%0d data=%h st=%b row=%0d",
                     $time, fb_we, fb_addr, fb_data, pixel_status_read, pixel_row,
                     ewe, ea, ed, est, m_row);
      end
   end

   // write monitor for literal checks
   int          wr_count = 0;
   logic [23:0] last_data = '0;
   int          last_addr = 0;
   always @(posedge clk_clk) begin
      if (fb_we === 1'b1) begin
         wr_count++;
         last_addr = int'(fb_addr);
         last_data = fb_data;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, need %0h", nm, act, exp);
   endtask

   task automatic wait_ack(input logic lvl, input string nm);
      int n;
      n = 0;
      while (pixel_status_read[SR_ACK] !== lvl && n < 20) begin
         @(negedge clk_clk);
         n++;
      end
      chk(nm, 32'(pixel_status_read[SR_ACK]), 32'(lvl));
   endtask

   task automatic frame_start();
      pixel_status_write[SW_FRAME_START] = 1'b1;
      @(negedge clk_clk);
      pixel_status_write[SW_FRAME_START] = 1'b0;
      repeat (D + 1) @(negedge clk_clk);
   endtask

   task automatic send_pixel(input logic [15:0] idx, input logic [23:0] d);
      pixel_index_in_row = idx;
      pixel_data = d;
      pixel_status_write[SW_VALID] = 1'b1;
      wait_ack(1'b1, "pix_ack_hi");
      pixel_status_write[SW_VALID] = 1'b0;
      wait_ack(1'b0, "pix_ack_lo");
   endtask

   task automatic row_done();
      pixel_status_write[SW_ROW_DONE] = 1'b1;
      wait_ack(1'b1, "row_ack_hi");
      pixel_status_write[SW_ROW_DONE] = 1'b0;
      wait_ack(1'b0, "row_ack_lo");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w;
      pixel_status_write = 4'b0000;
      pixel_data = '0;
      pixel_index_in_row = '0;
      reset_reset_n = 1'b0;
      repeat (3) @(negedge clk_clk);
      chk("rst_row", 32'(pixel_row), 0);
      chk("rst_status", 32'(pixel_status_read), 0);
      chk("rst_we", 32'(fb_we), 0);
      chk("rst_addr", 32'(fb_addr), 0);
      chk("rst_data", 32'(fb_data), 0);
      reset_reset_n = 1'b1;
      repeat (2) @(negedge clk_clk);
      chk("idle_not_ready", 32'(pixel_status_read[SR_READY]), 0);

      // first pixel: latency, address and data
      frame_start();
      chk("ready_after_fs", 32'(pixel_status_read[SR_READY]), 1);
      pixel_data = 24'hFF8000;
      pixel_index_in_row = 16'd5;
      pixel_status_write[SW_VALID] = 1'b1;
      repeat (LAT) @(negedge clk_clk);
      chk("first_we", 32'(fb_we), 1);
      chk("first_addr", 32'(fb_addr), 5);
      chk("first_data", 32'(fb_data), 32'h00FF8000);
      chk("first_ack", 32'(pixel_status_read[SR_ACK]), 1);
      pixel_status_write[SW_VALID] = 1'b0;
      wait_ack(1'b0, "first_release");

      // full row 0 with the reserved bit toggled on, then advance
      pixel_status_write[3] = 1'b1;
      for (int i = 0; i < H; i++) send_pixel(16'(i), {8'(i), 8'h5A, 8'(i >> 3)});
      pixel_status_write[3] = 1'b0;
      row_done();
      chk("row_after_adv", 32'(pixel_row), 1);
      send_pixel(16'd0, 24'h00C0DE);
      chk("row1_addr", 32'(last_addr), 640);
      chk("row1_data", 32'(last_data), 32'h0000C0DE);

      // out-of-row index
      w = wr_count;
      send_pixel(16'd640, 24'hBADBAD);
      chk("oob_no_write", 32'(wr_count), 32'(w));
      chk("oob_error", 32'(pixel_status_read[SR_ERROR]), 1);

      // walk to the last row and wrap
      for (int r = 1; r < V - 1; r++) row_done();
      chk("row_last", 32'(pixel_row), 479);
      chk("err_sticky", 32'(pixel_status_read[SR_ERROR]), 1);
      row_done();
      chk("wrap_row", 32'(pixel_row), 0);
      chk("wrap_done", 32'(pixel_status_read[SR_FRAME_DONE]), 1);
      chk("wrap_not_ready", 32'(pixel_status_read[SR_READY]), 0);
      repeat (3) @(negedge clk_clk);
      chk("idle_stays", 32'(pixel_status_read[SR_READY]), 0);
      chk("err_until_fs", 32'(pixel_status_read[SR_ERROR]), 1);
      frame_start();
      chk("fs_clears_err", 32'(pixel_status_read[SR_ERROR]), 0);
      chk("fs_clears_done", 32'(pixel_status_read[SR_FRAME_DONE]), 0);

      // VALID and ROW_DONE together, VALID held 10 cycles
      w = wr_count;
      pixel_data = 24'h0A0B0C;
      pixel_index_in_row = 16'd3;
      pixel_status_write[SW_VALID]    = 1'b1;
      pixel_status_write[SW_ROW_DONE] = 1'b1;
      wait_ack(1'b1, "both_ack_hi");
      repeat (10) @(negedge clk_clk);
      chk("held_one_write", 32'(wr_count - w), 1);
      chk("held_addr", 32'(last_addr), 3);
      chk("held_no_adv", 32'(pixel_row), 0);
      pixel_status_write[SW_VALID]    = 1'b0;
      pixel_status_write[SW_ROW_DONE] = 1'b0;
      wait_ack(1'b0, "both_ack_lo");
      chk("still_row0", 32'(pixel_row), 0);
      row_done();
      chk("adv_after_cycle", 32'(pixel_row), 1);

      // abort during release at row 7
      for (int r = 1; r < 7; r++) row_done();
      chk("row7", 32'(pixel_row), 7);
      pixel_data = 24'h777777;
      pixel_index_in_row = 16'd2;
      pixel_status_write[SW_VALID] = 1'b1;
      wait_ack(1'b1, "r7_ack_hi");
      @(negedge clk_clk);
      chk("r7_addr", 32'(last_addr), 7 * 640 + 2);
      w = wr_count;
      pixel_status_write[SW_VALID] = 1'b0;
      pixel_status_write[SW_FRAME_START] = 1'b1;
      @(negedge clk_clk);
      pixel_status_write[SW_FRAME_START] = 1'b0;
      repeat (D + 1) @(negedge clk_clk);
      chk("abort_row", 32'(pixel_row), 0);
      chk("abort_ack", 32'(pixel_status_read[SR_ACK]), 0);
      chk("abort_no_write", 32'(wr_count), 32'(w));
      chk("abort_ready", 32'(pixel_status_read[SR_READY]), 1);

      // reset in the middle of a handshake
      pixel_data = 24'h444444;
      pixel_index_in_row = 16'd4;
      pixel_status_write[SW_VALID] = 1'b1;
      @(negedge clk_clk);
      reset_reset_n = 1'b0;
      w = wr_count;
      repeat (2) @(negedge clk_clk);
      chk("midrst_status", 32'(pixel_status_read), 0);
      chk("midrst_we", 32'(fb_we), 0);
      pixel_status_write[SW_VALID] = 1'b0;
      reset_reset_n = 1'b1;
      repeat (D + 2) @(negedge clk_clk);
      chk("midrst_no_write", 32'(wr_count), 32'(w));
      chk("midrst_idle", 32'(pixel_status_read[SR_READY]), 0);
      frame_start();
      send_pixel(16'd9, 24'h123456);
      chk("restart_addr", 32'(last_addr), 9);
      chk("restart_data", 32'(last_data), 32'h00123456);

      repeat (3) @(negedge clk_clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
